// File: rtl/stereo_pkg.sv
// Shared types for the stereo column interleaver: pixel type, FSM states, half-beat pixel count.
package stereo_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned PIX_N = 4;
  localparam int unsigned K     = PIX_N / 2;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_LO,
    EMIT_HI
  } il_state_e;

endpackage

// File: rtl/stereo_axis_fifo.sv
// Synchronous FIFO with async active-low pointer reset; one instance buffers each input view.
module stereo_axis_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/stereo_col_interleaver.sv
// Folds separate left/right gray AXI4-Stream views into one L,R,L,R column-interleaved stream.
// Optional sticky L/R sideband check enabled by defining STEREO_IL_SYNC_CHECK_EN.
module stereo_col_interleaver
  import stereo_pkg::*;
#(
  parameter int unsigned AXIS_TDATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PIX_PER_BEAT     = 4,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_l_tdata,
  input  logic                        s_axis_l_tvalid,
  output logic                        s_axis_l_tready,
  input  logic                        s_axis_l_tuser,
  input  logic                        s_axis_l_tlast,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_r_tdata,
  input  logic                        s_axis_r_tvalid,
  output logic                        s_axis_r_tready,
  input  logic                        s_axis_r_tuser,
  input  logic                        s_axis_r_tlast,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_lr_tdata,
  output logic                        m_axis_lr_tvalid,
  input  logic                        m_axis_lr_tready,
  output logic                        m_axis_lr_tuser,
  output logic                        m_axis_lr_tlast
`ifdef STEREO_IL_SYNC_CHECK_EN
  ,
  output logic                        sync_err
`endif
);

  localparam int unsigned W    = AXIS_TDATA_WIDTH;
  localparam int unsigned HALF = PIX_PER_BEAT / 2;

  logic         rdy_q;
  logic         l_push, r_push, pop;
  logic         l_full, l_empty, r_full, r_empty;
  logic [W+1:0] l_head, r_head;
  logic [W-1:0] lo_data, hi_data;
  logic         pair_avail, out_hs;

  il_state_e    state_q;
  logic [W-1:0] tdata_q, hi_data_q;
  logic         tvalid_q, tuser_q, tlast_q, hi_last_q;

  // Holds tready low through reset and for the first edge after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign s_axis_l_tready = rdy_q && !l_full;
  assign s_axis_r_tready = rdy_q && !r_full;
  assign l_push          = s_axis_l_tvalid && s_axis_l_tready;
  assign r_push          = s_axis_r_tvalid && s_axis_r_tready;

  stereo_axis_fifo #(
    .WIDTH (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_l (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .wr_en_i   (l_push),
    .wr_data_i ({s_axis_l_tuser, s_axis_l_tlast, s_axis_l_tdata}),
    .rd_en_i   (pop),
    .rd_data_o (l_head),
    .full_o    (l_full),
    .empty_o   (l_empty)
  );

  stereo_axis_fifo #(
    .WIDTH (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_r (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .wr_en_i   (r_push),
    .wr_data_i ({s_axis_r_tuser, s_axis_r_tlast, s_axis_r_tdata}),
    .rd_en_i   (pop),
    .rd_data_o (r_head),
    .full_o    (r_full),
    .empty_o   (r_empty)
  );

  assign pair_avail = !l_empty && !r_empty;
  assign out_hs     = tvalid_q && m_axis_lr_tready;
  assign pop        = pair_avail &&
                      ((state_q == IDLE) || ((state_q == EMIT_HI) && out_hs));

  always_comb begin
    lo_data = '0;
    hi_data = '0;
    for (int unsigned j = 0; j < HALF; j++) begin
      lo_data[(2*j)*DATA_WIDTH +: DATA_WIDTH]   = l_head[j*DATA_WIDTH +: DATA_WIDTH];
      lo_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = r_head[j*DATA_WIDTH +: DATA_WIDTH];
      hi_data[(2*j)*DATA_WIDTH +: DATA_WIDTH]   = l_head[(HALF+j)*DATA_WIDTH +: DATA_WIDTH];
      hi_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = r_head[(HALF+j)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A pop always loads LO, whether from IDLE or chained straight off the HI handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      tvalid_q  <= 1'b0;
      tuser_q   <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      hi_data_q <= '0;
      hi_last_q <= 1'b0;
    end else if (pop) begin
      state_q   <= EMIT_LO;
      tvalid_q  <= 1'b1;
      tdata_q   <= lo_data;
      tuser_q   <= l_head[W+1];
      tlast_q   <= 1'b0;
      hi_data_q <= hi_data;
      hi_last_q <= l_head[W];
    end else begin
      case (state_q)
        EMIT_LO: begin
          if (out_hs) begin
            state_q <= EMIT_HI;
            tdata_q <= hi_data_q;
            tuser_q <= 1'b0;
            tlast_q <= hi_last_q;
          end
        end
        EMIT_HI: begin
          if (out_hs) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_lr_tdata  = tdata_q;
  assign m_axis_lr_tvalid = tvalid_q;
  assign m_axis_lr_tuser  = tuser_q;
  assign m_axis_lr_tlast  = tlast_q;

`ifdef STEREO_IL_SYNC_CHECK_EN
  logic sync_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_err_q <= 1'b0;
    end else if (pop && (l_head[W+1:W] != r_head[W+1:W])) begin
      sync_err_q <= 1'b1;
    end
  end

  assign sync_err = sync_err_q;
`else
  logic r_side_unused;
  assign r_side_unused = ^r_head[W+1:W];
`endif

endmodule

// File: tb/tb_stereo_col_interleaver.sv
// Randomized self-checking bench for stereo_col_interleaver against a queue-based pairing model.
module tb_stereo_col_interleaver;

  localparam int unsigned W     = 32;
  localparam int unsigned DW    = 8;
  localparam int unsigned PPB   = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic         user;
    logic         last;
    logic [W-1:0] data;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [W-1:0] l_tdata, r_tdata, m_tdata;
  logic         l_tvalid, l_tready, l_tuser, l_tlast;
  logic         r_tvalid, r_tready, r_tuser, r_tlast;
  logic         m_tvalid, m_tready, m_tuser, m_tlast;
`ifdef STEREO_IL_SYNC_CHECK_EN
  logic         sync_err;
  logic         model_sync;
`endif

  always #5 aclk = ~aclk;

  stereo_col_interleaver #(
    .AXIS_TDATA_WIDTH (W),
    .DATA_WIDTH       (DW),
    .PIX_PER_BEAT     (PPB),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_l_tdata   (l_tdata),
    .s_axis_l_tvalid  (l_tvalid),
    .s_axis_l_tready  (l_tready),
    .s_axis_l_tuser   (l_tuser),
    .s_axis_l_tlast   (l_tlast),
    .s_axis_r_tdata   (r_tdata),
    .s_axis_r_tvalid  (r_tvalid),
    .s_axis_r_tready  (r_tready),
    .s_axis_r_tuser   (r_tuser),
    .s_axis_r_tlast   (r_tlast),
    .m_axis_lr_tdata  (m_tdata),
    .m_axis_lr_tvalid (m_tvalid),
    .m_axis_lr_tready (m_tready),
    .m_axis_lr_tuser  (m_tuser),
    .m_axis_lr_tlast  (m_tlast)
`ifdef STEREO_IL_SYNC_CHECK_EN
    ,
    .sync_err         (sync_err)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: interleave all 2*PPB pixels of a pair, then cut into two beats.
  function automatic logic [W-1:0] fold(input logic [W-1:0] l, input logic [W-1:0] r, input bit hi);
    logic [DW-1:0] pix[$];
    logic [W-1:0]  o;
    for (int i = 0; i < PPB; i++) begin
      pix.push_back(l[i*DW +: DW]);
      pix.push_back(r[i*DW +: DW]);
    end
    o = '0;
    for (int i = 0; i < PPB; i++) begin
      o[i*DW +: DW] = pix[hi ? PPB + i : i];
    end
    return o;
  endfunction

  function automatic beat_t mk(input logic u, input logic l, input logic [W-1:0] d);
    beat_t b;
    b.user = u;
    b.last = l;
    b.data = d;
    return b;
  endfunction

  beat_t       lq[$], rq[$], expq[$];
  int unsigned out_cycles[$];
  int unsigned cyc = 0;

  initial begin
    beat_t a, b, held;
    bit    stalled;
    stalled = 1'b0;
    held    = '0;
`ifdef STEREO_IL_SYNC_CHECK_EN
    model_sync = 1'b0;
`endif
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        lq.delete();
        rq.delete();
        expq.delete();
        stalled = 1'b0;
`ifdef STEREO_IL_SYNC_CHECK_EN
        model_sync = 1'b0;
`endif
      end else begin
        if (l_tvalid && l_tready) lq.push_back(mk(l_tuser, l_tlast, l_tdata));
        if (r_tvalid && r_tready) rq.push_back(mk(r_tuser, r_tlast, r_tdata));
        while (lq.size() > 0 && rq.size() > 0) begin
          a = lq.pop_front();
          b = rq.pop_front();
`ifdef STEREO_IL_SYNC_CHECK_EN
          if (a.user != b.user || a.last != b.last) model_sync = 1'b1;
`endif
          expq.push_back(mk(a.user, 1'b0, fold(a.data, b.data, 1'b0)));
          expq.push_back(mk(1'b0, a.last, fold(a.data, b.data, 1'b1)));
        end
        if (stalled) begin
          check_val("hold_valid", 32'(m_tvalid), 32'd1);
          check_val("hold_data", m_tdata, held.data);
          check_val("hold_user", 32'(m_tuser), 32'(held.user));
          check_val("hold_last", 32'(m_tlast), 32'(held.last));
        end
        if (m_tvalid && m_tready) begin
          out_cycles.push_back(cyc);
          if (expq.size() == 0) begin
            check_val("spurious_beat", 32'(m_tvalid), 32'd0);
          end else begin
            a = expq.pop_front();
            check_val("out_data", m_tdata, a.data);
            check_val("out_user", 32'(m_tuser), 32'(a.user));
            check_val("out_last", 32'(m_tlast), 32'(a.last));
          end
        end
        stalled = m_tvalid && !m_tready;
        held    = mk(m_tuser, m_tlast, m_tdata);
      end
    end
  end

  // Output ready: 0 = always, 1 = 1,0,0,1 cycle, 2 = random ~70%, other = held low.
  int unsigned rdy_mode = 3;
  initial begin
    bit          pat[4];
    int unsigned pi;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pi  = 0;
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          m_tready = pat[pi];
          pi = (pi + 1) % 4;
        end
        2: m_tready = ($urandom_range(0, 9) < 7);
        default: m_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit side, input beat_t b, input logic v);
    if (side) begin
      r_tdata = b.data; r_tuser = b.user; r_tlast = b.last; r_tvalid = v;
    end else begin
      l_tdata = b.data; l_tuser = b.user; l_tlast = b.last; l_tvalid = v;
    end
  endtask

  task automatic send_seq(input bit side, input beat_t bs[$], input int unsigned max_gap);
    int unsigned t;
    foreach (bs[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge aclk);
        #1;
      end
      drive(side, bs[i], 1'b1);
      t = 0;
      do begin
        @(negedge aclk);
        t++;
      end while (!(side ? r_tready : l_tready) && t < 400);
      if (!(side ? r_tready : l_tready))
        check_val(side ? "r_hs_timeout" : "l_hs_timeout", 32'(side ? r_tready : l_tready), 32'd1);
      @(posedge aclk);
      #1;
      drive(side, '0, 1'b0);
    end
  endtask

  task automatic drain(input string tag);
    int unsigned t;
    t = 0;
    while ((expq.size() != 0 || m_tvalid) && t < 1000) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (expq.size() != 0 || m_tvalid)
      check_val(tag, 32'(expq.size()) + 32'(m_tvalid), 32'd0);
  endtask

  initial begin
    beat_t       lb[$], rb[$], lb2[$];
    logic        u, la;
    int unsigned base;

    aresetn  = 1'b0;
    rdy_mode = 3;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    check_val("rst_tvalid", 32'(m_tvalid), 32'd0);
    check_val("rst_tdata", m_tdata, 32'd0);
    check_val("rst_tuser", 32'(m_tuser), 32'd0);
    check_val("rst_tlast", 32'(m_tlast), 32'd0);
    check_val("rst_l_tready", 32'(l_tready), 32'd0);
    check_val("rst_r_tready", 32'(r_tready), 32'd0);
`ifdef STEREO_IL_SYNC_CHECK_EN
    check_val("rst_sync_err", 32'(sync_err), 32'd0);
`endif
    aresetn = 1'b1;
    #1;
    check_val("rel_l_tready_low", 32'(l_tready), 32'd0);
    @(posedge aclk);
    #1;
    check_val("rel_l_tready_high", 32'(l_tready), 32'd1);
    check_val("rel_r_tready_high", 32'(r_tready), 32'd1);

    // Single pair with the reference example and latency check.
    rdy_mode = 0;
    drive(1'b0, mk(1'b1, 1'b0, 32'h33221100), 1'b1);
    drive(1'b1, mk(1'b1, 1'b0, 32'h77665544), 1'b1);
    @(negedge aclk);
    check_val("t1_l_rdy", 32'(l_tready), 32'd1);
    @(posedge aclk);
    #1;
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    @(negedge aclk);
    check_val("t1_lat_early", 32'(m_tvalid), 32'd0);
    @(negedge aclk);
    check_val("t1_lo_valid", 32'(m_tvalid), 32'd1);
    check_val("t1_lo_data", m_tdata, 32'h55114400);
    check_val("t1_lo_user", 32'(m_tuser), 32'd1);
    check_val("t1_lo_last", 32'(m_tlast), 32'd0);
    @(negedge aclk);
    check_val("t1_hi_valid", 32'(m_tvalid), 32'd1);
    check_val("t1_hi_data", m_tdata, 32'h77336622);
    check_val("t1_hi_user", 32'(m_tuser), 32'd0);
    @(posedge aclk);
    #1;
    drain("t1_drain");

    // One line of 4 beats per side, continuous: 8 back-to-back output beats.
    lb.delete(); rb.delete();
    for (int i = 0; i < 4; i++) begin
      lb.push_back(mk(i == 0, i == 3, $urandom()));
      rb.push_back(mk(i == 0, i == 3, $urandom()));
    end
    base = out_cycles.size();
    fork
      send_seq(1'b0, lb, 0);
      send_seq(1'b1, rb, 0);
    join
    drain("t2_drain");
    check_val("t2_count", 32'(out_cycles.size() - base), 32'd8);
    if (out_cycles.size() >= base + 8)
      check_val("t2_back_to_back", out_cycles[base+7] - out_cycles[base], 32'd7);

    // Left runs four beats ahead of right.
    lb.delete(); rb.delete(); lb2.delete();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) lb.push_back(mk(i == 0, i == 7, $urandom()));
      else       lb2.push_back(mk(1'b0, i == 7, $urandom()));
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) rb.push_back(mk(lb[i].user, lb[i].last, $urandom()));
      else       rb.push_back(mk(lb2[i-4].user, lb2[i-4].last, $urandom()));
    end
    send_seq(1'b0, lb, 0);
    @(negedge aclk);
    check_val("t3_l_full_tready", 32'(l_tready), 32'd0);
    check_val("t3_r_tready", 32'(r_tready), 32'd1);
    check_val("t3_no_output", 32'(m_tvalid), 32'd0);
    @(posedge aclk);
    #1;
    fork
      send_seq(1'b0, lb2, 0);
      send_seq(1'b1, rb, 0);
    join
    drain("t3_drain");

    // Output backpressure 1,0,0,1 pattern.
    rdy_mode = 1;
    lb.delete(); rb.delete();
    for (int i = 0; i < 6; i++) begin
      lb.push_back(mk(i == 0, i == 5, $urandom()));
      rb.push_back(mk(i == 0, i == 5, $urandom()));
    end
    fork
      send_seq(1'b0, lb, 0);
      send_seq(1'b1, rb, 0);
    join
    drain("t4_drain");

    // Mid-frame reset while stalled in EMIT_LO with two pairs queued.
    rdy_mode = 3;
    lb.delete(); rb.delete();
    for (int i = 0; i < 3; i++) begin
      lb.push_back(mk(1'b0, 1'b0, $urandom()));
      rb.push_back(mk(1'b0, 1'b0, $urandom()));
    end
    fork
      send_seq(1'b0, lb, 0);
      send_seq(1'b1, rb, 0);
    join
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    check_val("t5_pre_valid", 32'(m_tvalid), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check_val("t5_rst_valid", 32'(m_tvalid), 32'd0);
    check_val("t5_rst_data", m_tdata, 32'd0);
    check_val("t5_rst_l_tready", 32'(l_tready), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    rdy_mode = 0;
    lb.delete(); rb.delete();
    lb.push_back(mk(1'b1, 1'b1, $urandom()));
    rb.push_back(mk(1'b1, 1'b1, $urandom()));
    fork
      send_seq(1'b0, lb, 0);
      send_seq(1'b1, rb, 0);
    join
    drain("t5_drain");
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check_val("t5_no_stale", 32'(m_tvalid), 32'd0);
    @(posedge aclk);
    #1;

`ifdef STEREO_IL_SYNC_CHECK_EN
    check_val("t6_sync_clean", 32'(sync_err), 32'd0);
    lb.delete(); rb.delete();
    lb.push_back(mk(1'b0, 1'b1, $urandom()));
    rb.push_back(mk(1'b0, 1'b0, $urandom()));
    fork
      send_seq(1'b0, lb, 0);
      send_seq(1'b1, rb, 0);
    join
    drain("t6_drain");
    check_val("t6_sync_set", 32'(sync_err), 32'd1);
    repeat (3) @(posedge aclk);
    #1;
    check_val("t6_sync_sticky", 32'(sync_err), 32'd1);
`endif

    // Random traffic with random gaps and random output backpressure.
    rdy_mode = 2;
    lb.delete(); rb.delete();
    for (int i = 0; i < 40; i++) begin
      u  = (i % 10 == 0);
      la = (i % 5 == 4);
      lb.push_back(mk(u, la, $urandom()));
      if ($urandom_range(0, 7) == 0) rb.push_back(mk(~u, la, $urandom()));
      else                           rb.push_back(mk(u, la, $urandom()));
    end
    fork
      send_seq(1'b0, lb, 3);
      send_seq(1'b1, rb, 3);
    join
    drain("rand_drain");
`ifdef STEREO_IL_SYNC_CHECK_EN
    check_val("rand_sync_err", 32'(sync_err), 32'(model_sync));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
